// File: rtl/dti_fifo_rd_ctrl_pkg.sv
// Shared definitions for the dti_fifo read/write pointer controllers.
package dti_fifo_rd_ctrl_pkg;

  // Default depth of the pointer-crossing synchroniser.
  localparam int unsigned DTI_DEF_SYNC_STAGES = 2;

  // Pointer width: one extra MSB over the RAM address separates full from empty.
  function automatic int unsigned dti_ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  // Binary to Gray conversion, shared with the write-side controller.
  function automatic logic [31:0] dti_bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/dti_fifo_rd_ctrl_gray_to_bin.sv
// Combinational Gray to binary converter used on the synchronised write pointer.
module dti_gray_to_bin
  import dti_fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = dti_ptr_width(4)
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at and above its position.
  always_comb begin
    o_bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/dti_fifo_rd_ctrl.sv
// Read-domain pointer and flag controller of the dti_fifo asynchronous FIFO.
module dti_fifo_rd_ctrl
  import dti_fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = DTI_DEF_SYNC_STAGES,
  parameter int unsigned AE_THRESH   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam int unsigned PW = dti_ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [PW-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0] w_wgray_s;
  logic [PW-1:0] w_wbin_s;

  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rgray;
  logic          r_empty;
  logic          r_almost_empty;
  logic [PW-1:0] r_rd_level;
  logic          r_underflow;

  logic          w_rd_fire;
  logic [PW-1:0] w_rbin_nxt;
  logic [PW-1:0] w_rgray_nxt;
  logic [PW-1:0] w_level_nxt;

  // Write-pointer synchroniser: one flop per stage, first stage samples the async input.
  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    if (g == 0) begin : g_first
      // Capture the asynchronous Gray write pointer.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync[0] <= '0;
        else        r_sync[0] <= wptr_gray;
      end
    end else begin : g_rest
      // Shift the pointer one stage further into the read domain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync[g] <= '0;
        else        r_sync[g] <= r_sync[g-1];
      end
    end
  end

  assign w_wgray_s = r_sync[SYNC_STAGES-1];

  dti_gray_to_bin #(
    .WIDTH (PW)
  ) u_gray_to_bin (
    .i_gray (w_wgray_s),
    .o_bin  (w_wbin_s)
  );

  // Next read pointer and the level it leaves against the synchronised write pointer.
  always_comb begin
    w_rd_fire   = rd_en & ~r_empty;
    w_rbin_nxt  = r_rbin + {{(PW-1){1'b0}}, w_rd_fire};
    w_rgray_nxt = PW'(dti_bin2gray(32'(w_rbin_nxt)));
    w_level_nxt = w_wbin_s - w_rbin_nxt;
  end

  // Read pointers and registered flags; flags are computed from the post-read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rbin         <= '0;
      r_rgray        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_level     <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_rbin         <= w_rbin_nxt;
      r_rgray        <= w_rgray_nxt;
      r_empty        <= (w_rgray_nxt == w_wgray_s);
      r_almost_empty <= (w_level_nxt <= AE_T);
      r_rd_level     <= w_level_nxt;
      r_underflow    <= rd_en & r_empty;
    end
  end

  assign raddr        = r_rbin[ADDR_WIDTH-1:0];
  assign rptr_gray    = r_rgray;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign rd_level     = r_rd_level;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_dti_fifo_rd_ctrl.sv
// Directed bench for the dti_fifo read-side controller (ADDR_WIDTH=4, SYNC_STAGES=2, AE_THRESH=1).
module tb_dti_fifo_rd_ctrl;

  logic       clk;
  logic       rst_n;
  logic       rd_en;
  logic [4:0] wptr_gray;
  logic [3:0] raddr;
  logic [4:0] rptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_level;
  logic       underflow;

  int n_checks = 0;
  int n_err    = 0;

  dti_fifo_rd_ctrl #(
    .ADDR_WIDTH  (4),
    .SYNC_STAGES (2),
    .AE_THRESH   (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .wptr_gray    (wptr_gray),
    .raddr        (raddr),
    .rptr_gray    (rptr_gray),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] g5(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_ae"},    32'(almost_empty), 32'd1);
    chk({tag, "_level"}, 32'(rd_level), 32'd0);
    chk({tag, "_rptr"},  32'(rptr_gray), 32'd0);
    chk({tag, "_uf"},    32'(underflow), 32'd0);
    chk({tag, "_raddr"}, 32'(raddr), 32'd0);
  endtask

  logic [7:0] mem [16];
  int         rc, wc, cyc;
  logic       fire, rdr, saw_wrap;
  logic [4:0] prev_rg;
  logic [3:0] prev_ra;

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; wptr_gray = '0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_en = 1'($urandom_range(0, 1));
      wptr_gray = 5'($urandom);
      #2;
      chk_reset("rst_hold");
    end
    @(negedge clk);
    rd_en = 1'b0; wptr_gray = '0; rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_empty", 32'(empty), 32'd1);

    // Single write, three-edge visibility
    wptr_gray = 5'b00001;
    @(negedge clk); chk("wr_lat1_empty", 32'(empty), 32'd1);
    @(negedge clk); chk("wr_lat2_empty", 32'(empty), 32'd1);
    @(negedge clk); chk("wr_lat3_empty", 32'(empty), 32'd0);
    chk("wr_level", 32'(rd_level), 32'd1);
    chk("wr_ae", 32'(almost_empty), 32'd1);
    chk("wr_raddr", 32'(raddr), 32'd0);
    rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    chk("rd1_raddr", 32'(raddr), 32'd1);
    chk("rd1_empty", 32'(empty), 32'd1);
    chk("rd1_rptr", 32'(rptr_gray), 32'b00001);
    chk("rd1_level", 32'(rd_level), 32'd0);
    chk("rd1_uf", 32'(underflow), 32'd0);

    // Full FIFO from fresh reset
    rst_n = 1'b0; wptr_gray = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    wptr_gray = 5'b11000;
    repeat (3) @(negedge clk);
    chk("full_level", 32'(rd_level), 32'd16);
    chk("full_empty", 32'(empty), 32'd0);
    chk("full_ae", 32'(almost_empty), 32'd0);
    rd_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("drain_raddr", 32'(raddr), 32'(k % 16));
      chk("drain_level", 32'(rd_level), 32'(16 - k));
      chk("drain_empty", 32'(empty), 32'(k == 16));
      chk("drain_ae", 32'(almost_empty), 32'((16 - k) <= 1));
      chk("drain_uf", 32'(underflow), 32'd0);
    end
    rd_en = 1'b0;
    chk("drain_rptr", 32'(rptr_gray), 32'b11000);

    // Underflow while empty
    rd_en = 1'b1;
    #1 chk("uf_pre", 32'(underflow), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("uf_pulse", 32'(underflow), 32'd1);
      chk("uf_raddr", 32'(raddr), 32'd0);
      chk("uf_rptr", 32'(rptr_gray), 32'b11000);
      chk("uf_empty", 32'(empty), 32'd1);
    end
    rd_en = 1'b0;
    @(negedge clk);
    chk("uf_post", 32'(underflow), 32'd0);

    // Streaming with random gaps across the pointer wrap
    rc = 16; wc = 16; cyc = 0; saw_wrap = 1'b0;
    prev_rg = rptr_gray; prev_ra = raddr;
    while (rc < 56 && cyc < 3000) begin
      chk("st_raddr", 32'(raddr), 32'(rc % 16));
      chk("st_rptr", 32'(rptr_gray), 32'(g5(rc % 32)));
      chk("st_rg_step", 32'($countones(prev_rg ^ rptr_gray) <= 1), 32'd1);
      chk("st_lvl_cons", 32'(int'(rd_level) <= (wc - rc)), 32'd1);
      if (prev_ra == 4'd15 && raddr == 4'd0) saw_wrap = 1'b1;
      prev_rg = rptr_gray; prev_ra = raddr;
      rdr  = 1'($urandom_range(0, 1));
      fire = rdr & ~empty;
      if (fire) begin
        chk("st_no_unwritten", 32'(rc < wc), 32'd1);
        chk("st_order", 32'(mem[raddr]), 32'(rc % 256));
      end
      rd_en = rdr;
      if (wc < 56 && (wc - rc) < 16 && $urandom_range(0, 2) != 0) begin
        mem[wc % 16] = 8'(wc);
        wc++;
        wptr_gray = g5(wc % 32);
      end
      if (fire) rc++;
      @(negedge clk);
      cyc++;
    end
    rd_en = 1'b0;
    chk("st_done", 32'(rc), 32'd56);
    chk("st_wrap_seen", 32'(saw_wrap), 32'd1);

    // Async reset mid-stream at level 7
    repeat (4) @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      wc++;
      wptr_gray = g5(wc % 32);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("ar_level7", 32'(rd_level), 32'd7);
    chk("ar_empty0", 32'(empty), 32'd0);
    chk("ar_ae0", 32'(almost_empty), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset("ar_async");
    wptr_gray = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); wptr_gray = g5(1);
    @(negedge clk); wptr_gray = g5(2);
    repeat (3) @(negedge clk);
    chk("resume_level", 32'(rd_level), 32'd2);
    chk("resume_empty", 32'(empty), 32'd0);
    chk("resume_ae", 32'(almost_empty), 32'd0);
    rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    chk("resume_raddr", 32'(raddr), 32'd1);
    chk("resume_lvl1", 32'(rd_level), 32'd1);
    chk("resume_ae1", 32'(almost_empty), 32'd1);
    chk("resume_rptr", 32'(rptr_gray), 32'b00001);
    chk("resume_empty1", 32'(empty), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
